// File: rtl/sevenseg_scan_driver_if.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_driver_if
//   Bundles the stopwatch-facing digit/mode inputs and the display-facing
//   segment/anode outputs of the seven-segment scan driver.
//
//   Signals
//     min_first_cnt  [3:0]  BCD tens of minutes
//     min_second_cnt [3:0]  BCD units of minutes
//     sec_first_cnt  [3:0]  BCD tens of seconds
//     sec_second_cnt [3:0]  BCD units of seconds
//     adj                   adjust mode (enables blinking)
//     sel                   adjust target: 0 = minutes, 1 = seconds
//     an             [3:0]  anode enables, active-low (an[3] = min_first)
//     seg            [6:0]  segments {g,f,e,d,c,b,a}, active-low
//     dp                    decimal point, active-low
//
//   Modports
//     master : the counter side, drives digits/mode and observes the display
//     slave  : the scan driver itself
// ---------------------------------------------------------------------------
interface sevenseg_scan_driver_if;
  logic [3:0] min_first_cnt;
  logic [3:0] min_second_cnt;
  logic [3:0] sec_first_cnt;
  logic [3:0] sec_second_cnt;
  logic       adj;
  logic       sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output min_first_cnt, min_second_cnt, sec_first_cnt, sec_second_cnt,
    output adj, sel,
    input  an, seg, dp
  );

  modport slave (
    input  min_first_cnt, min_second_cnt, sec_first_cnt, sec_second_cnt,
    input  adj, sel,
    output an, seg, dp
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_driver
//   Time-multiplexes four BCD digits onto a 4-digit common-anode
//   seven-segment display. Each digit owns the shared segment lines for
//   REFRESH_DIV clocks. The four digits are captured together at the start
//   of every scan frame so one frame never shows two different counter
//   values. In adjust mode the selected digit pair blinks with a half-period
//   of BLINK_TICKS digit slots.
//
//   Parameters
//     REFRESH_DIV  system clocks per digit slot (>= 2)
//     BLINK_TICKS  digit slots per blink half-period (>= 1)
//     DP_EN        1 = light the decimal point on the min_second digit
//
//   Ports
//     clk  system clock
//     rst  asynchronous reset, active-low
//     bus  slave modport of sevenseg_scan_driver_if (digits, adj/sel in;
//          an/seg/dp out, all outputs registered)
// ---------------------------------------------------------------------------
module sevenseg_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_TICKS = 250,
  parameter int DP_EN       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  sevenseg_scan_driver_if.slave bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);
  localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);

  // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 shows a dash.
  function automatic logic [6:0] f_decode(input logic [3:0] i_digit);
    logic [6:0] v;
    case (i_digit)
      4'd0:    v = 7'b1000000;
      4'd1:    v = 7'b1111001;
      4'd2:    v = 7'b0100100;
      4'd3:    v = 7'b0110000;
      4'd4:    v = 7'b0011001;
      4'd5:    v = 7'b0010010;
      4'd6:    v = 7'b0000010;
      4'd7:    v = 7'b1111000;
      4'd8:    v = 7'b0000000;
      4'd9:    v = 7'b0010000;
      default: v = 7'b0111111;
    endcase
    return v;
  endfunction

  logic [CNT_W-1:0]     r_refresh_cnt;
  logic [1:0]           r_idx;
  logic [3:0][3:0]      r_snap;
  logic [BLK_W-1:0]     r_blink_cnt;
  logic                 r_blink_phase;
  logic [3:0]           r_an;
  logic [6:0]           r_seg;
  logic                 r_dp;

  logic                 w_tick;
  logic                 w_frame_start;
  logic [1:0]           w_idx_next;
  logic [3:0][3:0]      w_live;
  logic [3:0]           w_digit;
  logic                 w_blank;
  logic [3:0]           w_an;
  logic [6:0]           w_seg;
  logic                 w_dp;

  // Packed so that index n lines up with an[n].
  assign w_live = {bus.min_first_cnt, bus.min_second_cnt,
                   bus.sec_first_cnt, bus.sec_second_cnt};

  // ---- slot timing ----
  assign w_tick        = (r_refresh_cnt == CNT_LAST);
  assign w_idx_next    = r_idx + 2'd1;
  assign w_frame_start = w_tick && (r_idx == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_refresh_cnt <= '0;
    end else if (w_tick) begin
      r_refresh_cnt <= '0;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx <= 2'd3;
    end else if (w_tick) begin
      r_idx <= w_idx_next;
    end
  end

  // ---- frame snapshot ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap <= '0;
    end else if (w_frame_start) begin
      r_snap <= w_live;
    end
  end

  // ---- blink timing ----
  // Leaving adjust mode clears the blink state on every clock, so that a
  // toggle coinciding with adj falling still leaves the phase at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (!bus.adj) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_tick) begin
      if (r_blink_cnt == BLK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + BLK_ONE;
      end
    end
  end

  // ---- next slot contents ----
  // The frame-start slot shows the live digit being captured on that same
  // edge; the snapshot register only holds it from the next clock.
  assign w_digit = (r_idx == 2'd3) ? w_live[w_idx_next] : r_snap[w_idx_next];

  // The blink phase used is the one in effect before this tick's update.
  // idx[1] = 1 marks the minute pair, idx[1] = 0 the second pair.
  assign w_blank = bus.adj && r_blink_phase &&
                   (bus.sel ? !w_idx_next[1] : w_idx_next[1]);

  assign w_an  = w_blank ? 4'b1111    : ~(4'b0001 << w_idx_next);
  assign w_seg = w_blank ? 7'b1111111 : f_decode(w_digit);
  assign w_dp  = !((DP_EN != 0) && (w_idx_next == 2'd2));

  // ---- output registers ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else if (w_tick) begin
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule
